// File: rtl/rr_mux_arbiter_if.sv
// Shared N:1 mux bus: per-requester beat inputs, one downstream output, arbiter status.
interface rr_mux_arbiter_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]        req_valid;
  logic [N-1:0][W-1:0] req_data;
  logic [N-1:0]        req_last;
  logic [N-1:0]        req_ready;
  logic                out_valid;
  logic [W-1:0]        out_data;
  logic                out_last;
  logic                out_ready;
  logic [IW-1:0]       grant_idx;
  logic                busy;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, grant_idx, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, grant_idx, busy
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin packet arbiter steering an N:1 mux; a grant is held until the owner's last beat.
module rr_mux_lane #(
  parameter int W = 8
) (
  input  logic         sel_i,
  input  logic         valid_i,
  input  logic         last_i,
  input  logic [W-1:0] data_i,
  input  logic         out_ready_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic         last_o,
  output logic [W-1:0] data_o
);
  assign valid_o = sel_i & valid_i;
  assign ready_o = sel_i & out_ready_i;
  assign last_o  = valid_o & last_i;
  assign data_o  = valid_o ? data_i : '0;
endmodule

module rr_mux_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  rr_mux_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, LOCK} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic                fire_last;
  logic [N-1:0]        sel, lane_vld, lane_last, lane_rdy;
  logic [N-1:0][W-1:0] lane_data;

  // First valid requester scanning ptr, ptr+1, ... with modulo-N wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!pick_found && bus.req_valid[(int'(ptr_q) + k) % N]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(ptr_q) + k) % N);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign sel[i] = (state_q == LOCK) && (grant_q == IW'(i));
    rr_mux_lane #(.W(W)) u_lane (
      .sel_i       (sel[i]),
      .valid_i     (bus.req_valid[i]),
      .last_i      (bus.req_last[i]),
      .data_i      (bus.req_data[i]),
      .out_ready_i (bus.out_ready),
      .ready_o     (lane_rdy[i]),
      .valid_o     (lane_vld[i]),
      .last_o      (lane_last[i]),
      .data_o      (lane_data[i])
    );
  end

  // At most one lane is selected, so an OR-reduce is the mux.
  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < N; i++) bus.out_data = bus.out_data | lane_data[i];
  end

  assign bus.out_valid = |lane_vld;
  assign bus.out_last  = |lane_last;
  assign bus.req_ready = lane_rdy;
  assign bus.grant_idx = grant_q;
  assign bus.busy      = (state_q == LOCK);
  assign fire_last     = bus.out_valid & bus.out_ready & bus.out_last;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (fire_last) begin
          state_d = IDLE;
          ptr_d   = (grant_q == IW'(N-1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: N=4 instance for most scenarios, N=3 instance for wrap.
module tb_rr_mux_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   beats  = 0;
  int   b0;

  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.N(4), .W(8)) if0 ();
  rr_mux_arbiter_if #(.N(3), .W(8)) if1 ();

  rr_mux_arbiter #(.N(4), .W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  rr_mux_arbiter #(.N(3), .W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always @(posedge clk)
    if (!rst && if0.out_valid && if0.out_ready) beats <= beats + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if0.req_valid = '0; if0.req_data = '0; if0.req_last = '0; if0.out_ready = 1'b0;
    if1.req_valid = '0; if1.req_data = '0; if1.req_last = '0; if1.out_ready = 1'b0;
    #1;
    chk("rst_busy",  32'(if0.busy),      32'd0);
    chk("rst_grant", 32'(if0.grant_idx), 32'd0);
    chk("rst_ovld",  32'(if0.out_valid), 32'd0);
    chk("rst_rdy",   32'(if0.req_ready), 32'd0);
    chk("rst_data",  32'(if0.out_data),  32'd0);
    chk("rst_last",  32'(if0.out_last),  32'd0);
    tick; tick;
    rst = 1'b0;

    // Simultaneous single-beat requests from all four
    if0.req_valid = 4'hF; if0.req_last = 4'hF; if0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) if0.req_data[i] = 8'(8'h10 + i);
    #1;
    chk("sim_idle_ovld", 32'(if0.out_valid), 32'd0);
    chk("sim_idle_rdy",  32'(if0.req_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("sim_grant", 32'(if0.grant_idx), 32'(k % 4));
      chk("sim_busy",  32'(if0.busy),      32'd1);
      chk("sim_data",  32'(if0.out_data),  32'(8'h10 + (k % 4)));
      chk("sim_rdy",   32'(if0.req_ready), 32'(1 << (k % 4)));
      chk("sim_last",  32'(if0.out_last),  32'd1);
      tick;
      chk("sim_gap_busy", 32'(if0.busy),      32'd0);
      chk("sim_gap_ovld", 32'(if0.out_valid), 32'd0);
      chk("sim_gap_data", 32'(if0.out_data),  32'd0);
    end
    if0.req_valid = '0;
    tick;
    chk("sim_done_busy", 32'(if0.busy), 32'd0);

    // Packet lock: req2 3-beat packet while req0 waits (ptr=1)
    if0.req_valid = 4'b0101; if0.req_last = 4'b0001;
    if0.req_data[2] = 8'hA1; if0.req_data[0] = 8'h55;
    tick;
    chk("lock_grant", 32'(if0.grant_idx), 32'd2);
    chk("lock_a1",    32'(if0.out_data),  32'hA1);
    chk("lock_last1", 32'(if0.out_last),  32'd0);
    chk("lock_rdy",   32'(if0.req_ready), 32'b0100);
    tick;
    if0.req_data[2] = 8'hA2; #1;
    chk("lock_a2", 32'(if0.out_data), 32'hA2);
    tick;
    if0.req_data[2] = 8'hA3; if0.req_last[2] = 1'b1; #1;
    chk("lock_a3",    32'(if0.out_data), 32'hA3);
    chk("lock_last3", 32'(if0.out_last), 32'd1);
    tick;
    if0.req_valid[2] = 1'b0; if0.req_last[2] = 1'b0; #1;
    chk("lock_bubble_busy", 32'(if0.busy),      32'd0);
    chk("lock_bubble_ovld", 32'(if0.out_valid), 32'd0);
    tick;
    chk("lock_next_grant", 32'(if0.grant_idx), 32'd0);
    chk("lock_next_data",  32'(if0.out_data),  32'h55);
    chk("lock_next_rdy",   32'(if0.req_ready), 32'b0001);
    tick;
    if0.req_valid = '0; if0.req_last = '0;

    // Backpressure: req1 2-beat packet, out_ready low 5 cycles on beat 2
    b0 = beats;
    if0.req_valid = 4'b0010; if0.req_data[1] = 8'hB1;
    tick;
    chk("bp_grant", 32'(if0.grant_idx), 32'd1);
    chk("bp_b1",    32'(if0.out_data),  32'hB1);
    chk("bp_rdy1",  32'(if0.req_ready), 32'b0010);
    tick;
    if0.req_data[1] = 8'hB2; if0.req_last[1] = 1'b1; if0.out_ready = 1'b0; #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_stall_data", 32'(if0.out_data),  32'hB2);
      chk("bp_stall_rdy",  32'(if0.req_ready), 32'd0);
      chk("bp_stall_ovld", 32'(if0.out_valid), 32'd1);
      chk("bp_stall_busy", 32'(if0.busy),      32'd1);
      tick;
    end
    if0.out_ready = 1'b1; #1;
    chk("bp_b2",    32'(if0.out_data),  32'hB2);
    chk("bp_last",  32'(if0.out_last),  32'd1);
    chk("bp_rdy2",  32'(if0.req_ready), 32'b0010);
    tick;
    if0.req_valid = '0; if0.req_last = '0;
    chk("bp_beats", 32'(beats - b0), 32'd2);

    // Valid gap: req2 drops valid mid-packet while req0 and req3 wait (ptr=2)
    if0.req_valid = 4'b1101; if0.req_data[2] = 8'hC1; if0.req_data[3] = 8'h33;
    tick;
    chk("gap_grant", 32'(if0.grant_idx), 32'd2);
    chk("gap_c1",    32'(if0.out_data),  32'hC1);
    tick;
    if0.req_valid[2] = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      chk("gap_busy",  32'(if0.busy),      32'd1);
      chk("gap_hold",  32'(if0.grant_idx), 32'd2);
      chk("gap_ovld",  32'(if0.out_valid), 32'd0);
      chk("gap_data",  32'(if0.out_data),  32'd0);
      chk("gap_rdy",   32'(if0.req_ready), 32'b0100);
      tick;
    end
    if0.req_valid[2] = 1'b1; if0.req_data[2] = 8'hC2; if0.req_last[2] = 1'b1; #1;
    chk("gap_c2",   32'(if0.out_data), 32'hC2);
    chk("gap_last", 32'(if0.out_last), 32'd1);
    tick;
    if0.req_valid[2] = 1'b0; if0.req_last[2] = 1'b0;
    tick;
    chk("gap_next_grant", 32'(if0.grant_idx), 32'd3);
    chk("gap_next_rdy",   32'(if0.req_ready), 32'b1000);

    // Reset mid-packet with req3 owning the mux, req0 still pending
    rst = 1'b1; #1;
    chk("mrst_ovld",  32'(if0.out_valid), 32'd0);
    chk("mrst_rdy",   32'(if0.req_ready), 32'd0);
    chk("mrst_busy",  32'(if0.busy),      32'd0);
    chk("mrst_grant", 32'(if0.grant_idx), 32'd0);
    #2 rst = 1'b0;
    tick;
    chk("mrst_regrant", 32'(if0.grant_idx), 32'd0);
    chk("mrst_rebusy",  32'(if0.busy),      32'd1);
    if0.req_valid = 4'b0001; if0.req_last = 4'b0001;
    tick;
    if0.req_valid = '0; if0.req_last = '0;

    // Wrap with N=3
    if1.req_valid = 3'b111; if1.req_last = 3'b111; if1.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) if1.req_data[i] = 8'(8'h20 + i);
    tick;
    chk("wrap_g0", 32'(if1.grant_idx), 32'd0);
    tick; tick;
    chk("wrap_g1", 32'(if1.grant_idx), 32'd1);
    tick;
    if1.req_valid = 3'b100;
    tick;
    chk("wrap_g2", 32'(if1.grant_idx), 32'd2);
    tick;
    if1.req_valid = 3'b101;
    tick;
    chk("wrap_grant", 32'(if1.grant_idx), 32'd0);
    chk("wrap_data",  32'(if1.out_data),  32'h20);
    if1.req_valid = '0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and sequencer for a shared N:1 data mux. It grants one requester at a time, steers the mux select to that requester, and holds the grant until the requester's packet completes. The output port feeds one downstream consumer over a valid/ready handshake. The block sits in front of any shared datapath resource that several producers must time-share.

## Interface
Parameters:
- N, 4, number of requesters (2..16).
- W, 8, data width per requester.
- IW, $clog2(N), width of the grant index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  N  per-requester beat valid.
- req_data  input  N*W  per-requester data; requester i occupies bits [i*W +: W].
- req_last  input  N  per-requester end-of-packet flag, qualified by req_valid.
- req_ready  output  N  per-requester beat accepted; at most one bit is set at a time.
- out_valid  output  1  shared output beat valid.
- out_data  output  W  shared output data (mux output).
- out_last  output  1  shared output end-of-packet flag.
- out_ready  input  1  downstream accepts the beat.
- grant_idx  output  IW  registered mux select (current or last owner).
- busy  output  1  1 while a grant is held (state LOCK).

## Operation
- States: IDLE and LOCK. Registers: state, grant_idx, ptr (IW bits, round-robin priority start).
- IDLE:
  - out_valid=0, req_ready=0.
  - If any req_valid is set, pick the first set bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Register that index into grant_idx and go to LOCK.
  - If no req_valid is set, stay in IDLE.
- LOCK: the mux passes the granted requester combinationally, with g = grant_idx.
  - out_valid = req_valid[g].
  - out_data = req_data[g].
  - out_last = req_last[g] & req_valid[g].
  - req_ready[g] = out_ready; all other req_ready bits are 0.
- A beat transfers when out_valid & out_ready.
  - If that beat has out_last=1: ptr <= (g+1) mod N, and state goes to IDLE on the next cycle.
  - Otherwise the block stays in LOCK.
- If the granted requester drops req_valid mid-packet, the grant holds. There is no timeout and no preemption.
- Non-granted requesters are never accepted. Their valid/data are ignored and must be held by the producers.
- Wrap: the ptr increment is modulo N, including non-power-of-two N (N-1 wraps to 0).
- out_data and out_last are 0 whenever out_valid=0.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, ptr=0, grant_idx=0, busy=0.
  - out_valid=0, out_data=0, out_last=0, req_ready=0.
- Arbitration latency: with req_valid asserted at cycle t in IDLE, grant_idx and busy update at edge t+1, and out_valid can be 1 in cycle t+1.
- Mux path in LOCK is zero-latency (combinational from req_* and out_ready).
- Packet gap: exactly one IDLE bubble cycle follows every last beat, even when the same or another requester is waiting.
- A single-beat packet (last=1 on the first beat) occupies 1 LOCK cycle plus 1 IDLE cycle, given out_ready=1.
- Simultaneous requests in IDLE are resolved strictly by ptr order. No requester waits more than N-1 packets.
- Reset asserted mid-packet: the grant is dropped immediately and req_ready goes to 0 in the same cycle. After release, arbitration restarts from ptr=0.
- out_ready low in LOCK: the beat stalls and all outputs hold their values, as long as the requester holds its inputs.

## Test plan
- **Reset:** assert rst during LOCK with out_ready=1 -> out_valid, req_ready and busy are 0 immediately; after release, grant_idx=0 and ptr=0.
- **Simultaneous requests:** N=4, all four assert req_valid with 1-beat packets continuously -> grant_idx sequence 0,1,2,3,0, one packet per 2 cycles.
- **Packet lock:** requester 2 sends a 3-beat packet (data 0xA1, 0xA2, 0xA3, last on the third beat) while requester 0 requests -> out_data is A1, A2, A3 contiguously; requester 0 is granted after the single bubble cycle.
- **Backpressure:** out_ready=0 for 5 cycles mid-packet -> out_data stable, req_ready[g]=0, no beat lost or duplicated.
- **Valid gap:** the granted requester drops valid for 3 cycles mid-packet while others request -> busy stays 1, grant_idx is unchanged, other req_ready bits stay 0.
- **Wrap with N=3:** requester 2 finishes, then requesters 0 and 2 both request -> requester 0 is granted (ptr wrapped to 0).
